stopwatch_lap: RTL and testbench

Parametrised single-clock stopwatch: counts MM:SS.cc in BCD from a divided CLK tick, with pause and a lap-capture FIFO. Successor to the three-process ripple-clocked stopwatch. All carries are in one clock domain using enables, and the rollover point is configurable. Lap times are buffered with a pop handshake. It sits between the board clock and the 7-segment display driver / lap readout logic.

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/stopwatch_lap_bcd_digit.sv | 30 +++
 rtl/stopwatch_lap.sv | 137 +++++++++++++
 tb/tb_stopwatch_lap.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch_lap slice.
//   DIGIT_W     : width of one BCD digit
//   LAP_W       : width of one packed lap entry {MH,ML,SH,SL,MSH,MSL}
//   DEC_LIMIT   : last value of a decimal digit
//   SEX_LIMIT   : last value of the seconds-tens digit
//   lap_entry_t : packed lap entry, MSB-first minutes down to centiseconds
package stopwatch_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned LAP_W   = 24;

    localparam logic [DIGIT_W-1:0] DEC_LIMIT = 4'd9;
    localparam logic [DIGIT_W-1:0] SEX_LIMIT = 4'd5;

    typedef struct packed {
        logic [DIGIT_W-1:0] mh;
        logic [DIGIT_W-1:0] ml;
        logic [DIGIT_W-1:0] sh;
        logic [DIGIT_W-1:0] sl;
        logic [DIGIT_W-1:0] msh;
        logic [DIGIT_W-1:0] msl;
    } lap_entry_t;

endpackage

// File: rtl/stopwatch_lap_bcd_digit.sv
// One BCD counter stage of the stopwatch chain.
//   clk   : rising-edge clock
//   clr   : synchronous clear, wins over en
//   en    : advance by one (wraps LIMIT -> 0)
//   digit : current digit value, never above LIMIT
//   carry : en and digit==LIMIT, enables the next stage in the same cycle
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] LIMIT = DEC_LIMIT
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               en,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry
);

    always_ff @(posedge clk) begin
        if (clr) begin
            digit <= '0;
        end else if (en) begin
            // >= rather than == keeps the digit legal even from a corrupted value
            digit <= (digit >= LIMIT) ? '0 : digit + 1'b1;
        end
    end

    assign carry = en && (digit == LIMIT);

endmodule

// File: rtl/stopwatch_lap.sv
// Single-clock MM:SS.cc BCD stopwatch with pause and lap-capture FIFO.
//   CLK        : system clock, rising edge
//   CLR        : synchronous active-high clear, highest priority
//   PAUSE      : freeze prescaler and digits
//   LAP        : lap request level, captured on its rising edge
//   LAP_RD     : pop the FIFO head (ignored when empty)
//   MSH..ML    : BCD digits, centiseconds/seconds/minutes hi and lo
//   ROLL       : one-cycle pulse when the time wraps to 00:00.00
//   LAP_VALID  : FIFO non-empty
//   LAP_DATA   : FIFO head {MH,ML,SH,SL,MSH,MSL}, fall-through
//   LAP_CNT    : entries held
//   LAP_OVF    : sticky, a lap was dropped because the FIFO was full
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 500000,
    parameter int unsigned MIN_LIMIT = 59,
    parameter int unsigned LAP_DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         CLR,
    input  logic                         PAUSE,
    input  logic                         LAP,
    input  logic                         LAP_RD,
    output logic [DIGIT_W-1:0]           MSH,
    output logic [DIGIT_W-1:0]           MSL,
    output logic [DIGIT_W-1:0]           SH,
    output logic [DIGIT_W-1:0]           SL,
    output logic [DIGIT_W-1:0]           MH,
    output logic [DIGIT_W-1:0]           ML,
    output logic                         ROLL,
    output logic                         LAP_VALID,
    output logic [LAP_W-1:0]             LAP_DATA,
    output logic [$clog2(LAP_DEPTH):0]   LAP_CNT,
    output logic                         LAP_OVF
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned AW = $clog2(LAP_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [PW-1:0]      PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [DIGIT_W-1:0] MIN_HI   = DIGIT_W'(MIN_LIMIT / 10);
    localparam logic [DIGIT_W-1:0] MIN_LO   = DIGIT_W'(MIN_LIMIT % 10);

    // ---------------- prescaler ----------------
    logic [PW-1:0] presc;
    logic          tick;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            presc <= '0;
        end else if (!PAUSE) begin
            presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
        end
    end

    assign tick = !PAUSE && (presc == PRE_LAST);

    // ---------------- digit chain ----------------
    logic c_msl, c_msh, c_sl, c_sh, c_ml, c_mh;
    logic wrap, clr_digits;

    // Wrap fires on the tick that would leave MIN_LIMIT:59.99.
    assign wrap = tick && (MH == MIN_HI) && (ML == MIN_LO) &&
                  (SH == SEX_LIMIT) && (SL == DEC_LIMIT) &&
                  (MSH == DEC_LIMIT) && (MSL == DEC_LIMIT);

    // c_mh only rises at 99:59.99, where the whole chain must clear anyway.
    assign clr_digits = CLR || wrap || c_mh;

    bcd_digit #(.LIMIT(DEC_LIMIT)) u_msl (.clk(CLK), .clr(clr_digits), .en(tick),  .digit(MSL), .carry(c_msl));
    bcd_digit #(.LIMIT(DEC_LIMIT)) u_msh (.clk(CLK), .clr(clr_digits), .en(c_msl), .digit(MSH), .carry(c_msh));
    bcd_digit #(.LIMIT(DEC_LIMIT)) u_sl  (.clk(CLK), .clr(clr_digits), .en(c_msh), .digit(SL),  .carry(c_sl));
    bcd_digit #(.LIMIT(SEX_LIMIT)) u_sh  (.clk(CLK), .clr(clr_digits), .en(c_sl),  .digit(SH),  .carry(c_sh));
    bcd_digit #(.LIMIT(DEC_LIMIT)) u_ml  (.clk(CLK), .clr(clr_digits), .en(c_sh),  .digit(ML),  .carry(c_ml));
    bcd_digit #(.LIMIT(DEC_LIMIT)) u_mh  (.clk(CLK), .clr(clr_digits), .en(c_ml),  .digit(MH),  .carry(c_mh));

    always_ff @(posedge CLK) begin
        if (CLR) begin
            ROLL <= 1'b0;
        end else begin
            ROLL <= wrap;
        end
    end

    // ---------------- lap FIFO ----------------
    lap_entry_t        mem [LAP_DEPTH];
    lap_entry_t        cur;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              lap_q, lap_edge, full, push, pop;

    assign cur      = {MH, ML, SH, SL, MSH, MSL};
    assign lap_edge = LAP && !lap_q;
    assign full     = (count == CW'(LAP_DEPTH));
    assign pop      = LAP_RD && (count != '0);
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign push     = lap_edge && (!full || pop);

    always_ff @(posedge CLK) begin
        if (push && !CLR) begin
            mem[wr_ptr] <= cur;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            lap_q   <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            LAP_OVF <= 1'b0;
        end else begin
            lap_q <= LAP;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (lap_edge && full && !pop) begin
                LAP_OVF <= 1'b1;
            end
        end
    end

    assign LAP_DATA  = mem[rd_ptr];
    assign LAP_VALID = (count != '0);
    assign LAP_CNT   = count;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Bench for stopwatch_lap: per-cycle scoreboard against a centisecond-count
// reference model, plus directed checks on lap FIFO and wrap behaviour.
module tb_stopwatch_lap;

    localparam int TD    = 2;
    localparam int MINL  = 1;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        PAUSE = 1'b0;
    logic        LAP = 1'b0;
    logic        LAP_RD = 1'b0;
    logic [3:0]  MSH, MSL, SH, SL, MH, ML;
    logic        ROLL, LAP_VALID, LAP_OVF;
    logic [23:0] LAP_DATA;
    logic [2:0]  LAP_CNT;

    stopwatch_lap #(.TICK_DIV(TD), .MIN_LIMIT(MINL), .LAP_DEPTH(DEPTH)) dut (
        .CLK(CLK), .CLR(CLR), .PAUSE(PAUSE), .LAP(LAP), .LAP_RD(LAP_RD),
        .MSH(MSH), .MSL(MSL), .SH(SH), .SL(SL), .MH(MH), .ML(ML),
        .ROLL(ROLL), .LAP_VALID(LAP_VALID), .LAP_DATA(LAP_DATA),
        .LAP_CNT(LAP_CNT), .LAP_OVF(LAP_OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [23:0] digits;
        logic        roll;
        logic [2:0]  cnt;
        logic        valid;
        logic        ovf;
        logic [23:0] head;
    } snap_t;

    snap_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // Reference model: time as a plain centisecond count.
    int          m_t = 0;
    int          m_phase = 0;
    bit          m_lap_prev = 0;
    bit          m_ovf = 0;
    bit          m_roll = 0;
    logic [23:0] m_fifo[$];

    function automatic logic [23:0] enc(input int t);
        int mn, s, cs;
        mn = t / 6000;
        s  = (t / 100) % 60;
        cs = t % 100;
        return {4'(mn / 10), 4'(mn % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    task automatic model_step(input bit clr, input bit pause, input bit lap, input bit rd);
        logic [23:0] cur;
        bit lap_edge, popped, full, tick;
        if (clr) begin
            m_t = 0; m_phase = 0; m_lap_prev = 0; m_ovf = 0; m_roll = 0;
            m_fifo.delete();
        end else begin
            cur      = enc(m_t);
            lap_edge = lap && !m_lap_prev;
            full     = (m_fifo.size() == DEPTH);
            popped   = rd && (m_fifo.size() > 0);
            if (popped) void'(m_fifo.pop_front());
            if (lap_edge) begin
                if (!full || popped) m_fifo.push_back(cur);
                else m_ovf = 1;
            end
            tick = !pause && (m_phase == TD - 1);
            if (!pause) m_phase = (m_phase + 1) % TD;
            m_roll = 0;
            if (tick) begin
                m_t++;
                if (m_t == (MINL + 1) * 6000) begin
                    m_t = 0;
                    m_roll = 1;
                end
            end
            m_lap_prev = lap;
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.digits = enc(m_t);
        s.roll   = m_roll;
        s.cnt    = 3'(m_fifo.size());
        s.valid  = (m_fifo.size() > 0);
        s.ovf    = m_ovf;
        s.head   = (m_fifo.size() > 0) ? m_fifo[0] : 24'h0;
        return s;
    endfunction

    // One clock cycle: drive at negedge, predict, return just after the edge.
    task automatic step(input bit clr, input bit pause, input bit lap, input bit rd);
        @(negedge CLK);
        CLR = clr; PAUSE = pause; LAP = lap; LAP_RD = rd;
        model_step(clr, pause, lap, rd);
        exp_q.push_back(model_snap());
        @(posedge CLK);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (m_t != target && guard < 20000) begin
            step(0, 0, 0, 0);
            guard++;
        end
        if (m_t != target) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_to: reached %0d expected %0d", m_t, target);
        end
    endtask

    function automatic logic [23:0] dut_digits();
        return {MH, ML, SH, SL, MSH, MSL};
    endfunction

    // Monitor: compares every cycle's outputs against the queued prediction.
    initial begin
        snap_t e, a;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.digits = dut_digits();
                a.roll   = ROLL;
                a.cnt    = LAP_CNT;
                a.valid  = LAP_VALID;
                a.ovf    = LAP_OVF;
                a.head   = LAP_VALID ? LAP_DATA : 24'h0;
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard: got t=%h roll=%b cnt=%0d v=%b ovf=%b head=%h expected t=%h roll=%b cnt=%0d v=%b ovf=%b head=%h at %0t",
                             a.digits, a.roll, a.cnt, a.valid, a.ovf, a.head,
                             e.digits, e.roll, e.cnt, e.valid, e.ovf, e.head, $time);
                end
                n_checks++;
                if (MSL > 4'd9 || MSH > 4'd9 || SL > 4'd9 || SH > 4'd5 || ML > 4'd9 || MH > 4'd9) begin
                    n_fail++;
                    $display("FAIL bcd_range: got %h required BCD with SH<=5", dut_digits());
                end
                if (n_fail >= 50) begin
                    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                    $finish;
                end
            end
        end
    end

    initial begin
        // reset and first-tick latency
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_digits", dut_digits(), 24'h0);
        check("rst_roll", ROLL, 0);
        check("rst_valid", LAP_VALID, 0);
        check("rst_cnt", LAP_CNT, 0);
        check("rst_ovf", LAP_OVF, 0);
        step(0, 0, 0, 0);
        check("first_tick_pre", dut_digits(), 24'h0);
        step(0, 0, 0, 0);
        check("first_tick", dut_digits(), 24'h000001);

        // two laps, pop both, extra pop ignored
        run_to(123);
        step(0, 0, 1, 0);
        run_to(250);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        check("lap_cnt2", LAP_CNT, 2);
        check("lap_head1", LAP_DATA, 24'h000123);
        step(0, 0, 0, 1);
        check("lap_head2", LAP_DATA, 24'h000250);
        check("lap_cnt1", LAP_CNT, 1);
        step(0, 0, 0, 1);
        check("lap_empty_valid", LAP_VALID, 0);
        step(0, 0, 0, 1);
        check("lap_empty_cnt", LAP_CNT, 0);
        check("lap_empty_ovf", LAP_OVF, 0);

        // overflow: five edges, fifth (00:00.04) dropped; full push+pop
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0);
            step(0, 0, 0, 0);
        end
        check("ovf_cnt", LAP_CNT, 4);
        check("ovf_flag", LAP_OVF, 1);
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);
        check("full_pushpop_cnt", LAP_CNT, 4);
        check("full_pushpop_ovf", LAP_OVF, 1);
        check("full_pushpop_head", LAP_DATA, 24'h000001);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("dropped_absent", LAP_DATA, 24'h000005);
        check("dropped_cnt", LAP_CNT, 1);

        // CLR with queued laps, set overflow and a coincident lap edge
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0);
            step(0, 0, 0, 0);
        end
        step(0, 0, 0, 1);
        run_to(4567);
        check("pre_clr_cnt", LAP_CNT, 3);
        check("pre_clr_digits", dut_digits(), 24'h004567);
        step(1, 1, 1, 0);
        check("clr_digits", dut_digits(), 24'h0);
        check("clr_cnt", LAP_CNT, 0);
        check("clr_ovf", LAP_OVF, 0);
        check("clr_valid", LAP_VALID, 0);
        step(0, 0, 0, 0);
        check("clr_no_capture", LAP_CNT, 0);

        // pause mid-prescale for 37 cycles: tick slips by exactly 37
        for (int i = 0; i < 37; i++) step(0, 1, 0, 0);
        check("pause_hold", dut_digits(), 24'h0);
        step(0, 0, 0, 0);
        check("pause_resume_tick", dut_digits(), 24'h000001);

        // long run, minute carry, wrap
        step(1, 0, 0, 0);
        run_to(6000);
        check("one_minute", dut_digits(), 24'h010000);
        run_to(11998);
        check("pre_wrap", dut_digits(), 24'h015998);
        for (int i = 0; i < 10 && !m_roll; i++) step(0, 0, 0, 0);
        check("wrap_digits", dut_digits(), 24'h0);
        check("wrap_roll", ROLL, 1);
        step(0, 0, 0, 0);
        check("roll_one_cycle", ROLL, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(499) == 0, $urandom_range(7) == 0,
                 $urandom_range(2) == 0, $urandom_range(3) == 0);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
